// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one single-cycle RV32I ALU between two requesters.
// Requests are granted one at a time, the ALU is driven from registered
// operands, and the captured result is returned tagged with the requester ID.
//
// Ports:
//   clk, resetN                       clock, asynchronous active-low reset
//   req0Valid/req0Ready/req0A/B/Ctrl  port 0 (core execute path) request
//   req1Valid/req1Ready/req1A/B/Ctrl  port 1 (debug/CSR client) request
//   aluA, aluB, aluCtrl               shared ALU operands and control code
//   aluResult, aluZero                shared ALU result and zero flag
//   rspValid/rspReady/rspId/rspResult/rspZero  response channel
//
// Build option:
//   ALU_ARB_FIXED_PRIORITY_EN  when defined, port 0 always wins contention;
//                              otherwise round-robin on the last grant.
module alu_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              req0Valid,
  output logic              req0Ready,
  input  logic [DATA_W-1:0] req0A,
  input  logic [DATA_W-1:0] req0B,
  input  logic [CTRL_W-1:0] req0Ctrl,
  input  logic              req1Valid,
  output logic              req1Ready,
  input  logic [DATA_W-1:0] req1A,
  input  logic [DATA_W-1:0] req1B,
  input  logic [CTRL_W-1:0] req1Ctrl,
  output logic [DATA_W-1:0] aluA,
  output logic [DATA_W-1:0] aluB,
  output logic [CTRL_W-1:0] aluCtrl,
  input  logic [DATA_W-1:0] aluResult,
  input  logic              aluZero,
  output logic              rspValid,
  input  logic              rspReady,
  output logic              rspId,
  output logic [DATA_W-1:0] rspResult,
  output logic              rspZero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              last_grant_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;
  logic [CTRL_W-1:0] op_ctrl_q;
  logic              op_id_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_zero_q;

  logic              any_valid_c;
  logic              grant_c;
  logic              can_accept_c;
  logic              fire_c;

  // Arbitration: pick the port that would be granted if a request is taken now.
  always_comb begin
    any_valid_c = req0Valid | req1Valid;
`ifdef ALU_ARB_FIXED_PRIORITY_EN
    grant_c = !req0Valid;
`else
    // Both valid: the port that did not win last time; otherwise the lone one.
    grant_c = (req0Valid && req1Valid) ? !last_grant_q : req1Valid;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (any_valid_c) state_d = EXEC;
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (rspReady) state_d = any_valid_c ? EXEC : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: a request is taken in IDLE, or in RESP as the response drains.
  always_comb begin
    can_accept_c = 1'b0;
    rspValid     = 1'b0;
    unique case (state_q)
      IDLE:    can_accept_c = 1'b1;
      EXEC:    can_accept_c = 1'b0;
      RESP: begin
        rspValid     = 1'b1;
        can_accept_c = rspReady;
      end
      default: can_accept_c = 1'b0;
    endcase
    // resetN gating keeps the readies low while reset is held.
    fire_c    = can_accept_c & any_valid_c & resetN;
    req0Ready = fire_c & !grant_c;
    req1Ready = fire_c &  grant_c;
  end

  // Operand capture on grant and result capture at the end of EXEC.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      last_grant_q <= 1'b1;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_ctrl_q    <= '0;
      op_id_q      <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      if (fire_c) begin
        last_grant_q <= grant_c;
        op_id_q      <= grant_c;
        op_a_q       <= grant_c ? req1A    : req0A;
        op_b_q       <= grant_c ? req1B    : req0B;
        op_ctrl_q    <= grant_c ? req1Ctrl : req0Ctrl;
      end
      if (state_q == EXEC) begin
        rsp_result_q <= aluResult;
        rsp_zero_q   <= aluZero;
        rsp_id_q     <= op_id_q;
      end
    end
  end

  assign aluA      = op_a_q;
  assign aluB      = op_b_q;
  assign aluCtrl   = op_ctrl_q;
  assign rspId     = rsp_id_q;
  assign rspResult = rsp_result_q;
  assign rspZero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: drivers push the expected response when a
// request is accepted; a monitor pops and compares on every response handshake.
module tb_alu_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;

  logic              clk;
  logic              resetN;
  logic              req0Valid, req0Ready;
  logic [DATA_W-1:0] req0A, req0B;
  logic [CTRL_W-1:0] req0Ctrl;
  logic              req1Valid, req1Ready;
  logic [DATA_W-1:0] req1A, req1B;
  logic [CTRL_W-1:0] req1Ctrl;
  logic [DATA_W-1:0] aluA, aluB;
  logic [CTRL_W-1:0] aluCtrl;
  logic [DATA_W-1:0] aluResult;
  logic              aluZero;
  logic              rspValid, rspReady, rspId, rspZero;
  logic [DATA_W-1:0] rspResult;

  typedef struct {
    logic              id;
    logic [DATA_W-1:0] res;
    logic              zero;
  } exp_t;

  exp_t q[$];
  int   grant_log[$];
  int   acc_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  alu_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .resetN(resetN),
    .req0Valid(req0Valid), .req0Ready(req0Ready),
    .req0A(req0A), .req0B(req0B), .req0Ctrl(req0Ctrl),
    .req1Valid(req1Valid), .req1Ready(req1Ready),
    .req1A(req1A), .req1B(req1B), .req1Ctrl(req1Ctrl),
    .aluA(aluA), .aluB(aluB), .aluCtrl(aluCtrl),
    .aluResult(aluResult), .aluZero(aluZero),
    .rspValid(rspValid), .rspReady(rspReady), .rspId(rspId),
    .rspResult(rspResult), .rspZero(rspZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Small ALU model: add, sub, and, or, xor, beq (compare by subtraction).
  always_comb begin
    case (aluCtrl)
      4'b0000: aluResult = aluA + aluB;
      4'b0001: aluResult = aluA - aluB;
      4'b0010: aluResult = aluA & aluB;
      4'b0011: aluResult = aluA | aluB;
      4'b0100: aluResult = aluA ^ aluB;
      4'b1001: aluResult = aluA - aluB;
      default: aluResult = '0;
    endcase
    aluZero = (aluResult == '0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (resetN && rspValid && rspReady) begin
      if (q.size() == 0) begin
        chk("unexpected_response", 32'(rspValid), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_id", 32'(rspId), 32'(e.id));
        chk("rsp_result", rspResult, e.res);
        chk("rsp_zero", 32'(rspZero), 32'(e.zero));
      end
    end
  end

  task automatic drive0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                        input logic [31:0] er, input logic ez);
    req0Valid = 1'b1; req0A = a; req0B = b; req0Ctrl = c;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req0Ready) begin
        q.push_back('{id: 1'b0, res: er, zero: ez});
        grant_log.push_back(0);
        acc_cyc.push_back(cyc);
        @(posedge clk); #1;
        req0Valid = 1'b0;
        return;
      end
    end
    chk("drive0_timeout", 32'd0, 32'd1);
    req0Valid = 1'b0;
  endtask

  task automatic drive1(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                        input logic [31:0] er, input logic ez);
    req1Valid = 1'b1; req1A = a; req1B = b; req1Ctrl = c;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req1Ready) begin
        q.push_back('{id: 1'b1, res: er, zero: ez});
        grant_log.push_back(1);
        acc_cyc.push_back(cyc);
        @(posedge clk); #1;
        req1Valid = 1'b0;
        return;
      end
    end
    chk("drive1_timeout", 32'd0, 32'd1);
    req1Valid = 1'b0;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req0Ready"}, 32'(req0Ready), 32'd0);
    chk({tag, "_req1Ready"}, 32'(req1Ready), 32'd0);
    chk({tag, "_rspValid"},  32'(rspValid),  32'd0);
    chk({tag, "_rspId"},     32'(rspId),     32'd0);
    chk({tag, "_rspResult"}, rspResult,      32'd0);
    chk({tag, "_rspZero"},   32'(rspZero),   32'd0);
    chk({tag, "_aluA"},      aluA,           32'd0);
    chk({tag, "_aluB"},      aluB,           32'd0);
    chk({tag, "_aluCtrl"},   32'(aluCtrl),   32'd0);
  endtask

  int exp_order[4];

  initial begin
    resetN = 1'b0; rspReady = 1'b1;
    req0Valid = 1'b0; req0A = '0; req0B = '0; req0Ctrl = '0;
    req1Valid = 1'b0; req1A = '0; req1B = '0; req1Ctrl = '0;
    #1;
    chk_reset_outputs("por");
    do_reset();

    // Single request: 5 + 3, accepted immediately, response two edges later.
    req0Valid = 1'b1; req0A = 32'd5; req0B = 32'd3; req0Ctrl = 4'b0000;
    @(negedge clk);
    chk("single_req0Ready", 32'(req0Ready), 32'd1);
    chk("single_req1Ready", 32'(req1Ready), 32'd0);
    q.push_back('{id: 1'b0, res: 32'd8, zero: 1'b0});
    @(posedge clk); #1;
    req0Valid = 1'b0;
    chk("single_aluA", aluA, 32'd5);
    chk("single_aluB", aluB, 32'd3);
    @(negedge clk);
    chk("single_exec_rspValid", 32'(rspValid), 32'd0);
    @(negedge clk);
    chk("single_resp_rspValid", 32'(rspValid), 32'd1);
    @(posedge clk); #1;

    // Contention from reset: both ports hold requests, rspReady high.
    do_reset();
    grant_log.delete(); acc_cyc.delete();
    fork
      begin
        drive0(32'd5, 32'd3, 4'b0000, 32'd8, 1'b0);
        drive0(32'd20, 32'd5, 4'b0001, 32'd15, 1'b0);
      end
      begin
        drive1(32'd12, 32'd10, 4'b0100, 32'd6, 1'b0);
        drive1(32'd1, 32'd2, 4'b0011, 32'd3, 1'b0);
      end
    join
`ifdef ALU_ARB_FIXED_PRIORITY_EN
    exp_order = '{0, 0, 1, 1};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    chk("contention_grants", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      chk($sformatf("grant_order_%0d", i), 32'(grant_log[i]), 32'(exp_order[i]));
      if (i > 0) chk($sformatf("accept_gap_%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
    end
    repeat (3) @(posedge clk); #1;

    // Backpressure: response held 5 cycles with req1 waiting.
    rspReady = 1'b0;
    drive0(32'd10, 32'd4, 4'b0001, 32'd6, 1'b0);
    fork
      drive1(32'd9, 32'd6, 4'b0010, 32'd0, 1'b1);
      begin
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk($sformatf("bp_rspValid_%0d", i), 32'(rspValid), 32'd1);
          chk($sformatf("bp_rspResult_%0d", i), rspResult, 32'd6);
          chk($sformatf("bp_rspId_%0d", i), 32'(rspId), 32'd0);
          chk($sformatf("bp_req1Ready_%0d", i), 32'(req1Ready), 32'd0);
        end
        @(posedge clk); #1;
        rspReady = 1'b1;
        @(negedge clk);
        chk("bp_release_req1Ready", 32'(req1Ready), 32'd1);
      end
    join
    repeat (3) @(posedge clk); #1;

    // Branch compare on port 1: 7 == 7 sets the zero flag.
    drive1(32'd7, 32'd7, 4'b1001, 32'd0, 1'b1);
    repeat (3) @(posedge clk); #1;

    // Reset mid-operation: in-flight op dropped, outputs cleared at once.
    drive0(32'hAA, 32'h11, 4'b0000, 32'hBB, 1'b0);
    resetN = 1'b0;
    q.delete();
    #1;
    chk_reset_outputs("midop");
    @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_reset_rspValid_%0d", i), 32'(rspValid), 32'd0);
    end
    @(posedge clk); #1;
    drive0(32'h30, 32'h0C, 4'b0100, 32'h3C, 1'b0);

    // Drain the scoreboard.
    for (int n = 0; n < 20 && q.size() != 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
